// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - decode-side bundle between ID stage and forwarding scoreboard
interface fwd_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int RW     = 5,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int SW     = $clog2(DEPTH + 1)
);
  logic                    issue_valid;
  logic                    issue_regwr;
  logic [RW-1:0]           issue_rd;
  logic                    issue_load;
  logic                    flush;
  logic [NSRC*RW-1:0]      src_rs;
  logic [NSRC-1:0]         src_used;
  logic [NSRC*DATA_W-1:0]  rf_data;
  logic [DEPTH*DATA_W-1:0] stage_data;
  logic                    cnt_clr;
  logic [NSRC*DATA_W-1:0]  src_data;
  logic [NSRC*SW-1:0]      fwd_sel;
  logic                    stall;
  logic [15:0]             stall_cnt;

  modport master (
    output issue_valid, issue_regwr, issue_rd, issue_load, flush,
    output src_rs, src_used, rf_data, stage_data, cnt_clr,
    input  src_data, fwd_sel, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_regwr, issue_rd, issue_load, flush,
    input  src_rs, src_used, rf_data, stage_data, cnt_clr,
    output src_data, fwd_sel, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight writer scoreboard: youngest-writer forwarding, load-use stall, stall counter
module fwd_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int RW       = 5,
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int SW       = $clog2(DEPTH + 1)
) (
  input  logic            CLK,
  input  logic            nRST,
  fwd_scoreboard_if.slave bus
);
  localparam logic [SW-1:0] ALU_RDY  = SW'(ALU_LAT);
  localparam logic [SW-1:0] LOAD_RDY = SW'(LOAD_LAT);

  logic [DEPTH-1:0]       slot_valid;
  logic [DEPTH-1:0]       slot_regwr;
  logic [DEPTH-1:0]       slot_load;
  logic [RW-1:0]          slot_rd [DEPTH];

  logic [NSRC-1:0]        raw_stall;
  logic                   stall;
  logic                   admit;
  logic [15:0]            stall_cnt_q;
  logic [NSRC*DATA_W-1:0] src_data_c;
  logic [NSRC*SW-1:0]     fwd_sel_c;

  assign admit = bus.issue_valid && !stall && !bus.flush;

  // Slots shift every edge; a stalled or flushed ID stage becomes a bubble in slot 0.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot_valid <= '0;
      slot_regwr <= '0;
      slot_load  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd[k] <= '0;
      end
    end else begin
      slot_valid[0] <= admit;
      slot_regwr[0] <= admit && bus.issue_regwr;
      slot_load[0]  <= admit && bus.issue_load;
      slot_rd[0]    <= bus.issue_rd;
      for (int k = 1; k < DEPTH; k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_regwr[k] <= slot_regwr[k-1];
        slot_load[k]  <= slot_load[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end
    end
  end

  always_comb begin
    logic              hit;
    logic              win_load;
    logic [SW-1:0]     win;
    logic [DATA_W-1:0] win_data;
    logic [RW-1:0]     rs;
    src_data_c = bus.rf_data;
    fwd_sel_c  = '0;
    raw_stall  = '0;
    hit        = 1'b0;
    win_load   = 1'b0;
    win        = '0;
    win_data   = '0;
    rs         = '0;
    for (int i = 0; i < NSRC; i++) begin
      rs       = bus.src_rs[i*RW +: RW];
      hit      = 1'b0;
      win_load = 1'b0;
      win      = '0;
      win_data = '0;
      // Scan oldest to youngest so the youngest matching writer is the one left standing.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_valid[k] && slot_regwr[k] && (slot_rd[k] == rs) &&
            (rs != '0) && bus.src_used[i]) begin
          hit      = 1'b1;
          win      = SW'(k);
          win_load = slot_load[k];
          win_data = bus.stage_data[k*DATA_W +: DATA_W];
        end
      end
      if (hit) begin
        if (win >= (win_load ? LOAD_RDY : ALU_RDY)) begin
          fwd_sel_c[i*SW +: SW]          = win + SW'(1);
          src_data_c[i*DATA_W +: DATA_W] = win_data;
        end else begin
          raw_stall[i] = 1'b1;
        end
      end
    end
  end

  assign stall = (|raw_stall) && !bus.flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.src_data  = src_data_c;
  assign bus.fwd_sel   = fwd_sel_c;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - scoreboard bench for fwd_scoreboard with directed vectors
module tb_fwd_scoreboard;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  fwd_scoreboard_if #(.DATA_W(32), .RW(5), .NSRC(2), .DEPTH(3), .SW(2)) bus ();
  fwd_scoreboard_if #(.DATA_W(32), .RW(5), .NSRC(2), .DEPTH(16), .SW(5)) bus2 ();

  fwd_scoreboard #(.DATA_W(32), .RW(5), .NSRC(2), .DEPTH(3), .ALU_LAT(0), .LOAD_LAT(1), .SW(2))
    dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  // Deep instance so the 16-bit stall counter can reach saturation in a short run.
  fwd_scoreboard #(.DATA_W(32), .RW(5), .NSRC(2), .DEPTH(16), .ALU_LAT(0), .LOAD_LAT(15), .SW(5))
    dut2 (.CLK(CLK), .nRST(nRST), .bus(bus2));

  typedef enum int {K_STALL, K_SEL0, K_SEL1, K_DAT0, K_DAT1, K_CNT, K_STALL2, K_SEL20, K_CNT2} kind_e;
  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t expq[$];
  event mon_ev;
  int   errors = 0;
  int   checks = 0;

  task automatic want(input string name, input kind_e kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.val  = val;
    expq.push_back(e);
  endtask

  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge CLK or mon_ev);
      while (expq.size() > 0) begin
        e = expq.pop_front();
        case (e.kind)
          K_STALL:  act = {31'd0, bus.stall};
          K_SEL0:   act = {30'd0, bus.fwd_sel[1:0]};
          K_SEL1:   act = {30'd0, bus.fwd_sel[3:2]};
          K_DAT0:   act = bus.src_data[31:0];
          K_DAT1:   act = bus.src_data[63:32];
          K_CNT:    act = {16'd0, bus.stall_cnt};
          K_STALL2: act = {31'd0, bus2.stall};
          K_SEL20:  act = {27'd0, bus2.fwd_sel[4:0]};
          default:  act = {16'd0, bus2.stall_cnt};
        endcase
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.val, $time);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    bus.issue_valid = 1'b0;
    bus.issue_regwr = 1'b0;
    bus.issue_rd    = '0;
    bus.issue_load  = 1'b0;
    bus.flush       = 1'b0;
    bus.src_used    = '0;
    bus.cnt_clr     = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic load);
    bus.issue_valid = 1'b1;
    bus.issue_regwr = 1'b1;
    bus.issue_rd    = rd;
    bus.issue_load  = load;
  endtask

  task automatic src(input int i, input logic [4:0] rs, input logic used, input logic [31:0] rf);
    bus.src_rs[i*5 +: 5]    = rs;
    bus.src_used[i]         = used;
    bus.rf_data[i*32 +: 32] = rf;
  endtask

  task automatic stage(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    bus.stage_data = {s2, s1, s0};
  endtask

  initial begin
    int          ph;
    int          post;
    logic [15:0] m_cnt;
    logic        s;

    bus.issue_valid = 0; bus.issue_regwr = 0; bus.issue_rd = 0; bus.issue_load = 0;
    bus.flush = 0; bus.src_rs = '0; bus.src_used = '0; bus.rf_data = '0;
    bus.stage_data = '0; bus.cnt_clr = 0;
    bus2.issue_valid = 0; bus2.issue_regwr = 0; bus2.issue_rd = 0; bus2.issue_load = 0;
    bus2.flush = 0; bus2.src_rs = '0; bus2.src_used = '0; bus2.rf_data = '0;
    bus2.stage_data = '0; bus2.cnt_clr = 0;

    // Reset state: everything passes the register file through.
    #1;
    src(0, 5'd5, 1'b1, 32'h11);
    want("rst_stall", K_STALL, 0);
    want("rst_sel0", K_SEL0, 0);
    want("rst_dat0", K_DAT0, 32'h11);
    want("rst_cnt", K_CNT, 0);
    next_cycle();
    nRST = 1'b1;
    issue(5'd5, 1'b0);
    want("alu_issue_stall", K_STALL, 0);

    next_cycle();
    stage(32'h1234, 32'h0, 32'h0);
    src(0, 5'd5, 1'b1, 32'h5555);
    src(1, 5'd7, 1'b1, 32'h77);
    want("alu_sel0", K_SEL0, 1);
    want("alu_dat0", K_DAT0, 32'h1234);
    want("alu_sel1_rf", K_SEL1, 0);
    want("alu_dat1_rf", K_DAT1, 32'h77);
    want("alu_stall", K_STALL, 0);

    next_cycle();
    issue(5'd8, 1'b1);
    want("ld_issue_stall", K_STALL, 0);

    next_cycle();
    stage(32'h0, 32'h8888, 32'h9999);
    src(1, 5'd8, 1'b1, 32'h0808);
    issue(5'd9, 1'b0);
    want("ld_use_stall", K_STALL, 1);
    want("ld_use_cnt0", K_CNT, 0);

    next_cycle();
    src(1, 5'd8, 1'b1, 32'h0808);
    issue(5'd9, 1'b0);
    want("ld_after_stall", K_STALL, 0);
    want("ld_sel1", K_SEL1, 2);
    want("ld_dat1", K_DAT1, 32'h8888);
    want("ld_cnt1", K_CNT, 1);

    next_cycle();
    stage(32'h4444, 32'h0, 32'h9999);
    src(0, 5'd9, 1'b1, 32'h0909);
    src(1, 5'd8, 1'b1, 32'h0808);
    want("wb_sel1", K_SEL1, 3);
    want("wb_dat1", K_DAT1, 32'h9999);
    want("post_stall_sel0", K_SEL0, 1);
    want("post_stall_dat0", K_DAT0, 32'h4444);

    next_cycle();
    issue(5'd3, 1'b0);
    next_cycle();
    next_cycle();
    issue(5'd3, 1'b0);
    next_cycle();
    stage(32'hBBBB, 32'hCCCC, 32'hAAAA);
    src(0, 5'd3, 1'b1, 32'h3);
    src(1, 5'd3, 1'b1, 32'h33);
    want("waw_sel0", K_SEL0, 1);
    want("waw_dat0", K_DAT0, 32'hBBBB);
    want("waw_sel1", K_SEL1, 1);
    want("waw_dat1", K_DAT1, 32'hBBBB);
    want("waw_stall", K_STALL, 0);

    next_cycle();
    issue(5'd0, 1'b1);
    next_cycle();
    src(0, 5'd0, 1'b1, 32'h0);
    want("r0_stall", K_STALL, 0);
    want("r0_sel0", K_SEL0, 0);
    want("r0_dat0", K_DAT0, 0);

    next_cycle();
    issue(5'd12, 1'b1);
    next_cycle();
    src(0, 5'd12, 1'b0, 32'h1200);
    want("unused_stall", K_STALL, 0);
    want("unused_sel0", K_SEL0, 0);
    want("unused_dat0", K_DAT0, 32'h1200);

    next_cycle();
    issue(5'd14, 1'b1);
    want("pre_flush_cnt", K_CNT, 1);
    next_cycle();
    src(0, 5'd14, 1'b1, 32'h1414);
    bus.flush = 1'b1;
    issue(5'd20, 1'b0);
    want("flush_stall", K_STALL, 0);
    want("flush_cnt", K_CNT, 1);
    next_cycle();
    stage(32'h0, 32'h7777, 32'h0);
    src(0, 5'd20, 1'b1, 32'h2020);
    src(1, 5'd14, 1'b1, 32'h1414);
    want("flushed_sel0", K_SEL0, 0);
    want("flushed_dat0", K_DAT0, 32'h2020);
    want("flush_shift_sel1", K_SEL1, 2);
    want("flush_shift_dat1", K_DAT1, 32'h7777);
    want("after_flush_cnt", K_CNT, 1);

    next_cycle();
    bus.cnt_clr = 1'b1;
    want("clr_sync_cnt", K_CNT, 1);
    next_cycle();
    want("clr_cnt", K_CNT, 0);
    issue(5'd15, 1'b1);
    next_cycle();
    src(0, 5'd15, 1'b1, 32'h0);
    bus.cnt_clr = 1'b1;
    want("clr_prio_stall", K_STALL, 1);
    next_cycle();
    want("clr_prio_cnt", K_CNT, 0);
    issue(5'd16, 1'b1);
    next_cycle();
    src(0, 5'd16, 1'b1, 32'h1616);
    want("pre_rst_stall", K_STALL, 1);
    next_cycle();
    src(0, 5'd16, 1'b1, 32'h1616);
    issue(5'd17, 1'b1);
    want("pre_rst_cnt", K_CNT, 1);
    next_cycle();
    src(0, 5'd17, 1'b1, 32'h1717);
    want("mid_stall", K_STALL, 1);
    #6;
    nRST = 1'b0;
    #1;
    want("async_rst_stall", K_STALL, 0);
    want("async_rst_sel0", K_SEL0, 0);
    want("async_rst_dat0", K_DAT0, 32'h1717);
    want("async_rst_cnt", K_CNT, 0);
    ->mon_ev;
    next_cycle();
    nRST = 1'b1;
    src(0, 5'd17, 1'b1, 32'h1717);
    src(1, 5'd16, 1'b1, 32'h1616);
    want("empty_stall", K_STALL, 0);
    want("empty_sel0", K_SEL0, 0);
    want("empty_sel1", K_SEL1, 0);
    want("empty_dat1", K_DAT1, 32'h1616);

    // Saturation on the deep instance: back-to-back load-use on r1 stalls 15 of every 16 cycles.
    next_cycle();
    bus2.issue_valid = 1'b1;
    bus2.issue_regwr = 1'b1;
    bus2.issue_rd    = 5'd1;
    bus2.issue_load  = 1'b1;
    bus2.src_rs      = {5'd0, 5'd1};
    bus2.src_used    = 2'b01;
    ph    = 0;
    post  = 0;
    m_cnt = 16'd0;
    for (int n = 0; n < 80000 && post < 40; n++) begin
      if (n > 0) begin
        @(posedge CLK);
        #1;
      end
      s = (ph != 0);
      if (n < 40 || m_cnt >= 16'hFFF0) begin
        want("sat_stall", K_STALL2, {31'd0, s});
        want("sat_cnt", K_CNT2, {16'd0, m_cnt});
        if (!s) want("sat_sel0", K_SEL20, (n == 0) ? 32'd0 : 32'd16);
      end
      if (s && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      ph = (ph == 15) ? 0 : ph + 1;
      if (m_cnt == 16'hFFFF) post++;
    end
    @(posedge CLK);
    #1;
    bus2.issue_valid = 1'b0;
    bus2.src_used    = 2'b00;
    bus2.cnt_clr     = 1'b1;
    want("sat_held", K_CNT2, 32'hFFFF);
    want("sat_hold_stall", K_STALL2, 0);
    @(posedge CLK);
    #1;
    bus2.cnt_clr = 1'b0;
    want("sat_clr", K_CNT2, 0);

    @(negedge CLK);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
